// File: rtl/im_port_sequencer.sv
// ============================================================================
// Module  : im_port_sequencer
// Brief   : Shares the single instruction-memory port between fetch, a program
//           loader and a debug reader, and sequences load-then-run.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module im_port_sequencer #(
    parameter int ADDR_W        = 11,
    parameter int DATA_W        = 32,
    parameter int STARVE_MAX    = 8,
    parameter int LOAD_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_vld,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_stall,
    output logic              cpu_hold,
    input  logic              ld_start,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    output logic              ld_rdy,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DBG   = 2'd2
    } tag_t;

    state_t             state_q, state_d;
    tag_t               tag_q, tag_d;
    logic [CNT_W-1:0]   starve_q, starve_d;

    logic fetch_gnt;
    logic dbg_gnt;
    logic dbg_live;
    logic starved;
    logic fetch_addr_unused;

    assign fetch_addr_unused = ^fetch_addr[31:ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if (LOAD_ON_RESET != 0) begin
                state_q <= ST_LOAD;
            end else begin
                state_q <= ST_RUN;
            end
            tag_q    <= TAG_NONE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tag_d     = TAG_NONE;
        starve_d  = starve_q;
        fetch_gnt = 1'b0;
        dbg_gnt   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        ld_rdy    = 1'b0;

        // A debug read already awaiting its ack must not be granted a second time.
        dbg_live = dbg_req && (tag_q != TAG_DBG);
        starved  = dbg_live && (starve_q == CNT_W'(STARVE_MAX));

        // Port outputs are gated by rst so an asserted reset silences the port at once.
        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    if (fetch_req && !starved) begin
                        fetch_gnt = 1'b1;
                    end else if (dbg_live) begin
                        dbg_gnt = 1'b1;
                    end
                    if (ld_start) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    ld_rdy    = 1'b1;
                    mem_we    = ld_wr;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_data;
                    if (ld_done) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase

            if (fetch_gnt) begin
                mem_addr = fetch_addr[ADDR_W-1:0];
                tag_d    = TAG_FETCH;
            end else if (dbg_gnt) begin
                mem_addr = dbg_addr;
                tag_d    = TAG_DBG;
            end

            if (!dbg_live || dbg_gnt) begin
                starve_d = '0;
            end else if (fetch_gnt && (starve_q != CNT_W'(STARVE_MAX))) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    assign fetch_stall = fetch_req && !fetch_gnt;
    assign cpu_hold    = (state_q != ST_RUN);
    assign fetch_vld   = (tag_q == TAG_FETCH);
    assign dbg_ack     = (tag_q == TAG_DBG);
    assign fetch_data  = fetch_vld ? mem_q : '0;
    assign dbg_data    = dbg_ack ? mem_q : '0;

endmodule

`default_nettype wire
